// File: rtl/write_sel_encoder.sv
// Write-select encoder: queues per-destination write requests and issues one per cycle
// as a registered code/one-hot grant. Define WRITE_SEL_FIXED_PRIO_EN for fixed priority.
module write_sel_encoder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       stall,
   input  logic       ovr_clr,
   output logic [3:0] selection_en,
   output logic [7:0] grant,
   output logic [7:0] pending,
   output logic       busy,
   output logic       overrun
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ARB  = 1'b1;

   logic [0:0] state_p0;
   logic [0:0] state_nxt;
   logic [2:0] issue_idx_p0;
   logic       issue_vld_p0;
   logic [7:0] issue_oh_p0;
   logic [7:0] pending_nxt;
   logic       ovr_set;

`ifdef WRITE_SEL_FIXED_PRIO_EN
   // Lowest pending index wins: PC highest, TR lowest.
   always_comb begin
      issue_idx_p0 = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pending[i]) issue_idx_p0 = 3'(i);
      end
   end
`else
   logic [2:0] last_idx;
   logic [2:0] probe;
   logic       found;

   // Rotating search starting just after the last issued index.
   always_comb begin
      issue_idx_p0 = 3'd0;
      probe        = 3'd0;
      found        = 1'b0;
      for (int i = 0; i < 8; i++) begin
         probe = last_idx + 3'd1 + 3'(i);
         if (!found && pending[probe]) begin
            issue_idx_p0 = probe;
            found        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_idx <= 3'd7;
      else if (issue_vld_p0)
         last_idx <= issue_idx_p0;
   end
`endif

   always_comb begin
      issue_vld_p0 = !stall && (pending != 8'h00);
      issue_oh_p0  = issue_vld_p0 ? (8'h01 << issue_idx_p0) : 8'h00;
      // A request landing on the edge its bit issues is a fresh request, not an overrun.
      pending_nxt  = (pending & ~issue_oh_p0) | req;
      ovr_set      = |(req & pending & ~issue_oh_p0);
      state_nxt    = (pending_nxt != 8'h00) ? ST_ARB : ST_IDLE;
   end

   // Stage boundary: issue decision registered onto the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0     <= ST_IDLE;
         pending      <= 8'h00;
         selection_en <= 4'd0;
         grant        <= 8'h00;
         overrun      <= 1'b0;
      end else begin
         state_p0     <= state_nxt;
         pending      <= pending_nxt;
         selection_en <= issue_vld_p0 ? ({1'b0, issue_idx_p0} + 4'd1) : 4'd0;
         grant        <= issue_oh_p0;
         if (ovr_set)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;
      end
   end

   assign busy = (state_p0 == ST_ARB);

endmodule

// File: tb/tb_write_sel_encoder.sv
// Directed table-driven bench for write_sel_encoder, plus hand sequences for
// latency, arbitration order, stall hold and asynchronous reset.
module tb_write_sel_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       stall;
   logic       ovr_clr;
   logic [3:0] selection_en;
   logic [7:0] grant;
   logic [7:0] pending;
   logic       busy;
   logic       overrun;

   int errors = 0;
   int checks = 0;

   write_sel_encoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .stall        (stall),
      .ovr_clr      (ovr_clr),
      .selection_en (selection_en),
      .grant        (grant),
      .pending      (pending),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       stall;
      logic [7:0] req;
      logic       ovr_clr;
      logic [3:0] sel;
      logic [7:0] gnt;
      logic [7:0] pend;
      logic       ovr;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] s, input logic [7:0] g,
                            input logic [7:0] p, input logic o);
      chk({tag, ".sel"},  {4'h0, selection_en}, {4'h0, s});
      chk({tag, ".gnt"},  grant, g);
      chk({tag, ".pend"}, pending, p);
      chk({tag, ".busy"}, {7'h0, busy}, {7'h0, (p != 8'h00)});
      chk({tag, ".ovr"},  {7'h0, overrun}, {7'h0, o});
   endtask

   // Apply inputs away from the edge, clock once, sample 1 ns after the edge.
   task automatic step(input logic st, input logic [7:0] r, input logic oc);
      stall   = st;
      req     = r;
      ovr_clr = oc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = 8'h00; stall = 1'b0; ovr_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [3:0] exp26 [3];
   logic [7:0] pend26[3];

   initial begin
      // stall, req, ovr_clr, sel, grant, pending, overrun
      tbl[0]  = '{1'b0, 8'hFF, 1'b0, 4'd0, 8'h00, 8'hFF, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 4'd1, 8'h01, 8'hFE, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 4'd2, 8'h02, 8'hFC, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 4'd3, 8'h04, 8'hF8, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 4'd4, 8'h08, 8'hF0, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 4'd5, 8'h10, 8'hE0, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 4'd6, 8'h20, 8'hC0, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 4'd7, 8'h40, 8'h80, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 4'd8, 8'h80, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0};
      // Re-request on the issuing edge: re-pends, no overrun.
      tbl[10] = '{1'b0, 8'h01, 1'b0, 4'd0, 8'h00, 8'h01, 1'b0};
      tbl[11] = '{1'b0, 8'h01, 1'b0, 4'd1, 8'h01, 8'h01, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 4'd1, 8'h01, 8'h00, 1'b0};
      // Overrun under stall, clear, set-wins, then a single DR issue.
      tbl[13] = '{1'b1, 8'h02, 1'b0, 4'd0, 8'h00, 8'h02, 1'b0};
      tbl[14] = '{1'b1, 8'h02, 1'b0, 4'd0, 8'h00, 8'h02, 1'b1};
      tbl[15] = '{1'b1, 8'h00, 1'b1, 4'd0, 8'h00, 8'h02, 1'b0};
      tbl[16] = '{1'b1, 8'h02, 1'b1, 4'd0, 8'h00, 8'h02, 1'b1};
      tbl[17] = '{1'b0, 8'h00, 1'b0, 4'd2, 8'h02, 8'h00, 1'b1};
      tbl[18] = '{1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1};
      tbl[19] = '{1'b0, 8'h00, 1'b1, 4'd0, 8'h00, 8'h00, 1'b0};

`ifdef WRITE_SEL_FIXED_PRIO_EN
      exp26[0] = 4'd3; pend26[0] = 8'h81;
      exp26[1] = 4'd1; pend26[1] = 8'h80;
      exp26[2] = 4'd8; pend26[2] = 8'h00;
`else
      exp26[0] = 4'd8; pend26[0] = 8'h05;
      exp26[1] = 4'd1; pend26[1] = 8'h04;
      exp26[2] = 4'd3; pend26[2] = 8'h00;
`endif

      do_reset();
      check_out("reset", 4'd0, 8'h00, 8'h00, 1'b0);

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].stall, tbl[i].req, tbl[i].ovr_clr);
         check_out($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].pend, tbl[i].ovr);
      end

      // Single PC request: latched, issued one edge later, busy for one cycle.
      do_reset();
      step(1'b0, 8'h01, 1'b0);
      check_out("pc.latch", 4'd0, 8'h00, 8'h01, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check_out("pc.issue", 4'd1, 8'h01, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check_out("pc.done", 4'd0, 8'h00, 8'h00, 1'b0);

      // Issue R5 alone so the rotation pointer sits at 6.
      step(1'b0, 8'h40, 1'b0);
      check_out("r5.latch", 4'd0, 8'h00, 8'h40, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check_out("r5.issue", 4'd7, 8'h40, 8'h00, 1'b0);
      step(1'b0, 8'h84, 1'b0);
      check_out("arb.latch", 4'd0, 8'h00, 8'h84, 1'b0);
      step(1'b0, 8'h01, 1'b0);
      check_out("arb.0", exp26[0], 8'h01 << (exp26[0] - 4'd1), pend26[0], 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check_out("arb.1", exp26[1], 8'h01 << (exp26[1] - 4'd1), pend26[1], 1'b0);
      step(1'b0, 8'h00, 1'b0);
      check_out("arb.2", exp26[2], 8'h01 << (exp26[2] - 4'd1), pend26[2], 1'b0);

      // R1 held across a 5-cycle stall, issued on the first edge after release.
      step(1'b1, 8'h04, 1'b0);
      check_out("stall.0", 4'd0, 8'h00, 8'h04, 1'b0);
      for (int i = 1; i < 5; i++) begin
         step(1'b1, 8'h00, 1'b0);
         check_out($sformatf("stall.%0d", i), 4'd0, 8'h00, 8'h04, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0);
      check_out("stall.rel", 4'd3, 8'h04, 8'h00, 1'b0);

      // Asynchronous reset mid-cycle with upper destinations pending and overrun set.
      step(1'b1, 8'hF0, 1'b0);
      check_out("rst.fill", 4'd0, 8'h00, 8'hF0, 1'b0);
      step(1'b1, 8'h10, 1'b0);
      check_out("rst.ovr", 4'd0, 8'h00, 8'hF0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("rst.async", 4'd0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      stall = 1'b0; req = 8'h00; ovr_clr = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b0);
         check_out($sformatf("rst.after%0d", i), 4'd0, 8'h00, 8'h00, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/write_sel_encoder.md
WRITE_SEL_ENCODER -- requirements
Module: write_sel_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (asynchronous active-low reset).
REQ-002 req input 8 SHALL carry write requests, one bit per destination: bit0 PC, bit1 DR, bit2 R1, bit3 R2, bit4 R3, bit5 R4, bit6 R5, bit7 TR.
REQ-003 stall input 1 SHALL, when high, suppress issue; pending requests are held.
REQ-004 ovr_clr input 1 SHALL be a synchronous clear of the overrun flag.
REQ-005 selection_en output 4 SHALL be the registered write-select code: 0 = no write, 1 PC, 2 DR, 3 R1, 4 R2, 5 R3, 6 R4, 7 R5, 8 TR; codes 9-15 are never driven.
REQ-006 grant output 8 SHALL be a registered one-hot pulse marking the destination issued this cycle, aligned with selection_en.
REQ-007 pending output 8 SHALL expose the pending-request register.
REQ-008 busy output 1 SHALL be high when pending is nonzero.
REQ-009 overrun output 1 SHALL be a sticky flag marking a request that arrived while the same bit was already pending.

Function
REQ-010 On each rising clk, pending SHALL update to (pending | req) with the bit issued this cycle cleared.
REQ-011 A req bit high on the same edge its pending bit is issued SHALL re-set that pending bit (new request, not overrun).
REQ-012 A req bit high while the same pending bit is set and not being issued SHALL set overrun; the request merges and is not queued twice.
REQ-013 Issue SHALL consider only the pending register; a req bit first asserted at edge N is issuable at edge N+1 at the earliest, so request-to-selection_en latency is 2 cycles minimum.
REQ-014 When stall is low and pending is nonzero, exactly one bit SHALL be issued per cycle; selection_en = index+1 and grant = one-hot of that index on the next edge.
REQ-015 When stall is high or pending is zero, selection_en and grant SHALL be 0 on the next edge.
REQ-016 Default arbitration SHALL be round-robin: search starts at the index after last_idx (wrap 7->0); last_idx updates only on issue; last_idx resets to 7, so the first search starts at PC.
REQ-017 selection_en and grant SHALL be 0 or a single code/bit for exactly one cycle per issue; back-to-back issues SHALL be allowed with no idle cycle.
REQ-018 ovr_clr and a new overrun on the same edge SHALL leave overrun set (set wins).
REQ-019 stall SHALL NOT alter last_idx or pending, except that new req bits are still accumulated.
REQ-020 The state machine SHALL be IDLE (pending==0) and ARB (pending!=0); IDLE->ARB when any req is latched; ARB->IDLE when the final pending bit is issued and no new req arrives on that edge.

Reset
REQ-021 While rst_n is low, selection_en=0, grant=0, pending=0, busy=0, overrun=0, last_idx=7 and state=IDLE SHALL hold, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard all pending requests; after release, no issue SHALL occur until req is sampled again.

Configuration
REQ-023 Macro WRITE_SEL_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority with lowest index first (PC highest, TR lowest) and last_idx is unused; when undefined, round-robin per REQ-016 applies.

Verification
REQ-024 Reset, then req=8'h01 for 1 cycle -> selection_en=1, grant=8'h01 exactly 2 cycles after the req edge, then 0; busy high for 1 cycle.
REQ-025 req=8'hFF for 1 cycle, stall=0 -> round-robin: selection_en=1,2,...,8 on 8 consecutive cycles, then 0; with WRITE_SEL_FIXED_PRIO_EN the same 1..8 order.
REQ-026 Pending R1 and TR with last_idx=6, plus req PC on the next cycle -> round-robin order 8,1,3; fixed priority order 3,1,8 with PC issued after arrival.
REQ-027 req=8'h04, stall=1 for 5 cycles, then stall=0 -> selection_en=0 throughout the stall, pending=8'h04, busy=1; selection_en=3 on the first edge after stall falls.
REQ-028 Pending DR held by stall, req bit1 pulsed again -> overrun=1 and remains set; ovr_clr for 1 cycle -> overrun=0; DR issued once only.
REQ-029 rst_n low asynchronously while pending=8'hF0 -> all outputs 0 immediately; after release with req=0, selection_en stays 0.
